serdes_link_ctrl: RTL and testbench

//  Half-duplex link sequencer for the SERDES pin pair (ser_in/ser_out).
//  - Frames parallel TX words as start(0) + DATA_W bits LSB-first + stop(1).
//  - Deframes RX words the same way.
//  - Arbitrates the single shift path between TX and RX; RX wins ties.
//  - Sits between the parallel user interface (ui_in/uo_out side) and the serial pins in tt_um_serdes.

---
 rtl/serdes_link_ctrl.sv | 173 +++++++++++++++++
 tb/tb_serdes_link_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/serdes_link_ctrl.sv
// Half-duplex SERDES link sequencer: frames TX words, deframes RX words and
// arbitrates the single shift path between them, with RX winning ties.
module serdes_link_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              ser_out,
  input  logic              ser_in,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_err,
  output logic              busy
);

  localparam int unsigned DivW = $clog2(DIV);
  localparam int unsigned BitW = $clog2(DATA_W);

  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam logic [DivW-1:0] DivHalf = DivW'(DIV / 2 - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTxStart,
    StTxData,
    StTxStop,
    StRxStart,
    StRxData,
    StRxStop
  } state_e;

  state_e            state_q, state_d;
  logic [DivW-1:0]   div_cnt_q, div_cnt_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              rx_err_q, rx_err_d;
  logic              ser_meta_q, ser_s_q;
  logic              started_q;
  logic              div_tick;
  logic              half_tick;

  // Two-flop synchroniser; resets to the idle line level so reset cannot fake a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ser_meta_q <= 1'b1;
      ser_s_q    <= 1'b1;
    end else begin
      ser_meta_q <= ser_in;
      ser_s_q    <= ser_meta_q;
    end
  end

  // Keeps tx_ready low between reset release and the first clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started_q <= 1'b0;
    end else begin
      started_q <= 1'b1;
    end
  end

  assign div_tick  = (div_cnt_q == DivLast);
  assign half_tick = (div_cnt_q == DivHalf);
  assign tx_ready  = started_q && (state_q == StIdle) && ser_s_q;
  assign busy      = (state_q != StIdle);
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_err    = rx_err_q;

  always_comb begin
    ser_out = 1'b1;
    case (state_q)
      StTxStart: ser_out = 1'b0;
      StTxData:  ser_out = tx_shift_q[0];
      default:   ser_out = 1'b1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_tick ? '0 : div_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;

    case (state_q)
      StIdle: begin
        div_cnt_d = '0;
        if (!ser_s_q) begin
          state_d = StRxStart;
        end else if (tx_valid && tx_ready) begin
          tx_shift_d = tx_data;
          state_d    = StTxStart;
        end
      end
      StTxStart: begin
        if (div_tick) state_d = StTxData;
      end
      StTxData: begin
        if (div_tick) begin
          tx_shift_d = tx_shift_q >> 1;
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) state_d = StTxStop;
        end
      end
      StTxStop: begin
        if (div_tick) state_d = StIdle;
      end
      StRxStart: begin
        // Mid-start-bit check rejects glitches shorter than half a bit.
        if (half_tick) state_d = ser_s_q ? StIdle : StRxData;
      end
      StRxData: begin
        if (div_tick) begin
          rx_shift_d = {ser_s_q, rx_shift_q[DATA_W-1:1]};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BitLast) state_d = StRxStop;
        end
      end
      StRxStop: begin
        if (div_tick) begin
          state_d = StIdle;
          if (ser_s_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            rx_err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) begin
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

endmodule

// File: tb/tb_serdes_link_ctrl.sv
// Bench for serdes_link_ctrl: directed and randomized frames checked against a
// bit-list model of the serial framing rules.
module tb_serdes_link_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned DV = 4;
  localparam int unsigned FrameCyc = (DW + 2) * DV;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          ser_out;
  logic          ser_in;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_err;
  logic          busy;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] good_word;

  serdes_link_ctrl #(
    .DATA_W(DW),
    .DIV   (DV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ser_out (ser_out),
    .ser_in  (ser_in),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .rx_err  (rx_err),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge just before the accepting edge (tx_valid high, tx_data = data).
  task automatic tx_frame(input logic [DW-1:0] data);
    logic [DW+1:0] bits;
    int            bad;
    bits = {1'b1, data, 1'b0};
    bad  = 0;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = DW'($urandom);
    for (int j = 0; j < int'(FrameCyc); j++) begin
      // Line noise during TX must be ignored; settle high before the frame ends.
      ser_in = (j < int'(FrameCyc - 2 * DV)) ? 1'($urandom_range(0, 1)) : 1'b1;
      if ({ser_out, busy, tx_ready, rx_valid, rx_err} !== {bits[j/DV], 4'b1000}) bad++;
      if (j % int'(DV) == int'(DV) - 1)
        check($sformatf("tx_bit%0d", j / DV), 32'(ser_out), 32'(bits[j/DV]));
      @(negedge clk);
    end
    check("tx_frame_cycles", 32'(bad), 32'd0);
    check("tx_end_ready", 32'({busy, tx_ready}), 32'b01);
  endtask

  task automatic send_tx(input logic [DW-1:0] data);
    check("tx_ready_idle", 32'(tx_ready), 32'd1);
    tx_data  = data;
    tx_valid = 1'b1;
    tx_frame(data);
  endtask

  task automatic send_rx(input logic [DW-1:0] data, input logic stop);
    logic [DW+1:0] bits;
    int            nv, ne, both, low;
    logic [DW-1:0] seen;
    bits = {stop, data, 1'b0};
    nv = 0; ne = 0; both = 0; low = 0; seen = '0;
    for (int j = 0; j < int'(FrameCyc + 3 * DV); j++) begin
      ser_in = (j < int'(FrameCyc)) ? bits[j/DV] : 1'b1;
      if (rx_valid) begin nv++; seen = rx_data; end
      if (rx_err) ne++;
      if (rx_valid && rx_err) both++;
      if (!ser_out) low++;
      if (j == int'(5 * DV)) check("rx_mid_busy", 32'({busy, tx_ready}), 32'b10);
      @(negedge clk);
    end
    if (stop) good_word = data;
    check("rx_valid_pulses", 32'(nv), stop ? 32'd1 : 32'd0);
    check("rx_err_pulses", 32'(ne), stop ? 32'd0 : 32'd1);
    check("rx_both_high", 32'(both), 32'd0);
    check("rx_ser_out_low", 32'(low), 32'd0);
    if (stop) check("rx_word_at_pulse", 32'(seen), 32'(data));
    check("rx_data_held", 32'(rx_data), 32'(good_word));
    check("rx_back_idle", 32'({busy, tx_ready}), 32'b01);
  endtask

  task automatic glitch();
    int n;
    n = 0;
    ser_in = 1'b0;
    @(negedge clk);
    ser_in = 1'b1;
    for (int j = 0; j < int'(3 * DV); j++) begin
      if (rx_valid || rx_err) n++;
      @(negedge clk);
    end
    check("glitch_pulses", 32'(n), 32'd0);
    check("glitch_rx_data", 32'(rx_data), 32'(good_word));
    check("glitch_idle", 32'({busy, tx_ready}), 32'b01);
  endtask

  // TX request raised the very cycle the synchronised line first reads low.
  task automatic rx_then_tx(input logic [DW-1:0] rxw, input logic [DW-1:0] txw);
    logic [DW+1:0] bits;
    int            nv, low;
    bit            accepted;
    bits = {1'b1, rxw, 1'b0};
    nv = 0; low = 0; accepted = 1'b0;
    for (int j = 0; j < int'(FrameCyc + 20); j++) begin
      ser_in = (j < int'(FrameCyc)) ? bits[j/DV] : 1'b1;
      if (j == 2) begin
        check("tie_tx_ready_low", 32'(tx_ready), 32'd0);
        tx_data  = txw;
        tx_valid = 1'b1;
      end
      if (rx_valid) nv++;
      if (!ser_out) low++;
      if (j > 2 && tx_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("tie_accepted", 32'(accepted), 32'd1);
    check("tie_rx_first", 32'(nv), 32'd1);
    check("tie_ser_out_low", 32'(low), 32'd0);
    good_word = rxw;
    check("tie_rx_data", 32'(rx_data), 32'(good_word));
    if (accepted) tx_frame(txw);
    else tx_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] w;
    rst_n     = 1'b0;
    ser_in    = 1'b1;
    tx_valid  = 1'b0;
    tx_data   = '0;
    good_word = '0;
    #1;
    check("reset_outputs", 32'({ser_out, busy, tx_ready, rx_valid, rx_err}), 32'b10000);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_clk", 32'(tx_ready), 32'd0);
    @(negedge clk);

    send_tx(8'hA5);
    send_rx(8'h3C, 1'b1);
    glitch();
    send_rx(8'h3C, 1'b0);
    rx_then_tx(8'h96, 8'h5B);

    // Reset in the middle of data bit 3 of an 8'hA5 frame (bit 3 drives 0).
    check("pre_reset_ready", 32'(tx_ready), 32'd1);
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (17) @(negedge clk);
    check("pre_reset_bit3", 32'({ser_out, busy}), 32'b01);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", 32'({ser_out, busy, tx_ready, rx_valid, rx_err}), 32'b10000);
    check("mid_reset_rx_data", 32'(rx_data), 32'd0);
    good_word = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", 32'(tx_ready), 32'd0);
    @(negedge clk);
    send_tx(8'h01);

    for (int i = 0; i < 10; i++) begin
      w = DW'($urandom);
      if ($urandom_range(0, 1) == 0) send_tx(w);
      else send_rx(w, ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
